// File: rtl/jackpot_n_if.sv
// Board-side bundle for the jackpot_n reaction game:
// switch/mode/enable in, LED pattern, pulses and score out.
interface jackpot_n_if #(
  parameter int N       = 4,
  parameter int SCORE_W = 8
);
  logic [N-1:0]       switches;
  logic               mode;
  logic               enable;
  logic [N-1:0]       leds;
  logic               win;
  logic               miss;
  logic [SCORE_W-1:0] score;

  modport master (
    output switches, mode, enable,
    input  leds, win, miss, score
  );

  modport slave (
    input  switches, mode, enable,
    output leds, win, miss, score
  );
endinterface

// File: rtl/jackpot_n.sv
// N-LED reaction game: a lit LED steps at a tick rate in wrap or
// bounce mode; raising exactly the lit switch scores a hit.
module jackpot_n #(
  parameter int N          = 4,
  parameter int DIV        = 6250000,
  parameter int HOLD_TICKS = 4,
  parameter int SCORE_W    = 8
) (
  input logic        clock,
  input logic        reset,
  jackpot_n_if.slave bus
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [PW-1:0] PEN  = PW'(N - 2);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS - 1);

  typedef enum logic {
    RUN,
    WIN
  } state_t;

  state_t state, state_n;

  logic [N-1:0]       sw_m;
  logic [N-1:0]       sw_s;
  logic [N-1:0]       sw_d;
  logic [N-1:0]       rise;
  logic [N-1:0]       lit;
  logic [PW-1:0]      pos, pos_n, step_pos;
  logic               dir, dir_n, step_dir;
  logic [CW-1:0]      cnt, cnt_n;
  logic [HW-1:0]      hold, hold_n;
  logic [SCORE_W-1:0] score, score_n;
  logic               win, win_n;
  logic               miss, miss_n;
  logic               tick;
  logic               hit;
  logic               wrong;

  assign rise  = sw_s & ~sw_d;
  assign lit   = {{(N-1){1'b0}}, 1'b1} << pos;
  assign tick  = (cnt == CMAX);
  assign hit   = (rise == lit);
  assign wrong = (|rise) & ~hit;

  assign bus.leds  = (state == WIN) ? '1 : lit;
  assign bus.win   = win;
  assign bus.miss  = miss;
  assign bus.score = score;

  // dir=1 is up; wrap always leaves dir up so bounce restarts upward
  always_comb begin
    step_pos = pos;
    step_dir = 1'b1;
    if (!bus.mode) begin
      step_pos = (pos == LAST) ? '0 : pos + 1'b1;
    end else if (pos == LAST) begin
      step_pos = PEN;
      step_dir = 1'b0;
    end else if (pos == '0) begin
      step_pos = PW'(1);
    end else if (dir) begin
      step_pos = pos + 1'b1;
    end else begin
      step_pos = pos - 1'b1;
      step_dir = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir;
    cnt_n   = cnt;
    hold_n  = hold;
    score_n = score;
    win_n   = 1'b0;
    miss_n  = 1'b0;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          hit: begin
            state_n = WIN;
            hold_n  = '0;
            cnt_n   = '0;
            win_n   = 1'b1;
            score_n = (&score) ? score : score + 1'b1;
          end
          wrong: begin
            pos_n  = '0;
            dir_n  = 1'b1;
            cnt_n  = '0;
            miss_n = 1'b1;
          end
          default: begin
            if (bus.enable) begin
              cnt_n = tick ? '0 : cnt + 1'b1;
              if (tick) begin
                pos_n = step_pos;
                dir_n = step_dir;
              end
            end
          end
        endcase
      end
      WIN: begin
        cnt_n = tick ? '0 : cnt + 1'b1;
        if (tick) begin
          if (hold == HMAX) begin
            state_n = RUN;
            pos_n   = '0;
            dir_n   = 1'b1;
            hold_n  = '0;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_m  <= '0;
      sw_s  <= '0;
      sw_d  <= '0;
      state <= RUN;
      pos   <= '0;
      dir   <= 1'b1;
      cnt   <= '0;
      hold  <= '0;
      score <= '0;
      win   <= 1'b0;
      miss  <= 1'b0;
    end else begin
      sw_m  <= bus.switches;
      sw_s  <= sw_m;
      sw_d  <= sw_s;
      state <= state_n;
      pos   <= pos_n;
      dir   <= dir_n;
      cnt   <= cnt_n;
      hold  <= hold_n;
      score <= score_n;
      win   <= win_n;
      miss  <= miss_n;
    end
  end

endmodule

// File: tb/tb_jackpot_n.sv
// Bench for jackpot_n: directed table and sequences plus randomized
// stimulus against a clock-level behavioural model.
module tb_jackpot_n;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int HOLD = 2;
  localparam int SW   = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  jackpot_n_if #(.N(N), .SCORE_W(SW)) bus ();

  jackpot_n #(
    .N(N), .DIV(DIV), .HOLD_TICKS(HOLD), .SCORE_W(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp,
               $time);
    end
  endtask

  // Reference model: position as an integer with a +1/-1 direction,
  // clocks-since-step phase, and a WIN countdown in clocks.
  int         m_pos   = 0;
  int         m_dir   = 1;
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_score = 0;
  bit         m_win   = 1'b0;
  bit         m_wp    = 1'b0;
  bit         m_mp    = 1'b0;
  logic [N-1:0] h0 = '0, h1 = '0, h2 = '0, m_rise;

  function automatic logic [N-1:0] m_leds();
    if (m_win) return '1;
    return N'(1 << m_pos);
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      h0 = '0; h1 = '0; h2 = '0;
      m_pos = 0; m_dir = 1; m_phase = 0; m_left = 0;
      m_score = 0; m_win = 1'b0; m_wp = 1'b0; m_mp = 1'b0;
    end else begin
      m_rise = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = bus.switches;
      m_wp = 1'b0;
      m_mp = 1'b0;
      if (m_win) begin
        m_left--;
        if (m_left == 0) begin
          m_win = 1'b0; m_pos = 0; m_dir = 1; m_phase = 0;
        end
      end else if (m_rise != '0) begin
        if (m_rise == m_leds()) begin
          m_win  = 1'b1;
          m_left = HOLD * DIV;
          m_wp   = 1'b1;
          if (m_score < (1 << SW) - 1) m_score++;
        end else begin
          m_mp = 1'b1; m_pos = 0; m_dir = 1; m_phase = 0;
        end
      end else if (bus.enable) begin
        m_phase++;
        if (m_phase == DIV) begin
          m_phase = 0;
          if (!bus.mode) begin
            m_pos = (m_pos + 1) % N;
            m_dir = 1;
          end else begin
            if (m_pos == N - 1) m_dir = -1;
            else if (m_pos == 0) m_dir = 1;
            m_pos += m_dir;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_on && !reset) begin
      check("model_leds", 32'(bus.leds), 32'(m_leds()));
      check("model_win", 32'(bus.win), 32'(m_wp));
      check("model_miss", 32'(bus.miss), 32'(m_mp));
      check("model_score", 32'(bus.score), 32'(m_score));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       mode;
    int         cycles;
    logic [3:0] leds;
  } step_t;

  step_t tbl[11];

  task automatic wait_leds(input logic [3:0] pat, input int budget);
    int i = 0;
    while (bus.leds !== pat && i < budget) begin
      @(negedge clock);
      i++;
    end
    check("wait_leds", 32'(bus.leds), 32'(pat));
  endtask

  task automatic win_len(output int dur);
    dur = 0;
    while (bus.leds === 4'hF && dur < 20) begin
      dur++;
      @(negedge clock);
    end
  endtask

  int dur;
  int r;

  initial begin
    tbl[0]  = '{1'b0, 4, 4'b0010};
    tbl[1]  = '{1'b0, 4, 4'b0100};
    tbl[2]  = '{1'b0, 4, 4'b1000};
    tbl[3]  = '{1'b0, 4, 4'b0001};
    tbl[4]  = '{1'b1, 4, 4'b0010};
    tbl[5]  = '{1'b1, 4, 4'b0100};
    tbl[6]  = '{1'b1, 4, 4'b1000};
    tbl[7]  = '{1'b1, 4, 4'b0100};
    tbl[8]  = '{1'b1, 4, 4'b0010};
    tbl[9]  = '{1'b1, 4, 4'b0001};
    tbl[10] = '{1'b1, 4, 4'b0010};

    bus.switches = '0;
    bus.mode     = 1'b0;
    bus.enable   = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_leds", 32'(bus.leds), 32'h1);
    check("rst_score", 32'(bus.score), 32'h0);
    check("rst_win", 32'(bus.win), 32'h0);
    check("rst_miss", 32'(bus.miss), 32'h0);
    reset  = 1'b0;
    chk_on = 1'b1;

    for (int i = 0; i < 11; i++) begin
      bus.mode = tbl[i].mode;
      repeat (tbl[i].cycles) @(negedge clock);
      check($sformatf("step%0d", i), 32'(bus.leds), 32'(tbl[i].leds));
    end

    // hit on 0100
    repeat (4) @(negedge clock);
    check("pre_hit", 32'(bus.leds), 32'h4);
    bus.switches = 4'b0100;
    repeat (3) @(negedge clock);
    check("hit_leds", 32'(bus.leds), 32'hF);
    check("hit_win", 32'(bus.win), 32'h1);
    check("hit_score", 32'(bus.score), 32'h1);
    bus.switches = '0;
    win_len(dur);
    check("hit_len", 32'(dur), 32'd8);
    check("hit_exit", 32'(bus.leds), 32'h1);

    // wrong bit, then extra bit alongside the lit one
    wait_leds(4'b0100, 40);
    bus.switches = 4'b0001;
    repeat (3) @(negedge clock);
    check("miss_pulse", 32'(bus.miss), 32'h1);
    check("miss_leds", 32'(bus.leds), 32'h1);
    check("miss_score", 32'(bus.score), 32'h1);
    bus.switches = '0;
    wait_leds(4'b0100, 40);
    bus.switches = 4'b1100;
    repeat (3) @(negedge clock);
    check("multi_miss", 32'(bus.miss), 32'h1);
    check("multi_leds", 32'(bus.leds), 32'h1);
    bus.switches = '0;

    for (int i = 0; i < 7; i++) begin
      wait_leds(4'b0001, 40);
      bus.switches = 4'b0001;
      repeat (3) @(negedge clock);
      check($sformatf("sat_win%0d", i), 32'(bus.win), 32'h1);
      bus.switches = '0;
    end
    check("sat_score", 32'(bus.score), 32'h7);

    // pause, hit while paused, press during WIN
    wait_leds(4'b0001, 40);
    bus.enable = 1'b0;
    repeat (24) @(negedge clock);
    check("pause_leds", 32'(bus.leds), 32'h1);
    bus.switches = 4'b0001;
    repeat (3) @(negedge clock);
    check("pause_hit", 32'(bus.win), 32'h1);
    bus.switches = '0;
    @(negedge clock);
    bus.switches = 4'b0010;
    win_len(dur);
    check("pause_win_len", 32'(dur), 32'd7);
    check("ign_leds", 32'(bus.leds), 32'h1);
    check("ign_score", 32'(bus.score), 32'h7);

    // hit lands on the tick edge
    bus.enable = 1'b1;
    @(negedge clock);
    bus.switches = 4'b0001;
    repeat (3) @(negedge clock);
    check("coll_win", 32'(bus.win), 32'h1);
    check("coll_leds", 32'(bus.leds), 32'hF);
    bus.switches = '0;
    win_len(dur);
    check("coll_len", 32'(dur), 32'd8);

    // reset mid-WIN
    bus.switches = 4'b0001;
    repeat (3) @(negedge clock);
    check("rw_win", 32'(bus.win), 32'h1);
    bus.switches = '0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rw_leds", 32'(bus.leds), 32'h1);
    check("rw_score", 32'(bus.score), 32'h0);
    check("rw_win0", 32'(bus.win), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      r = int'($urandom_range(0, 15));
      if (r < 10) bus.switches = '0;
      else if (r < 14) bus.switches = N'(1 << $urandom_range(0, N - 1));
      else bus.switches = N'($urandom);
      if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 99) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    end

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jackpot_n.md
# jackpot_n

Parametrised successor to the 4-LED reaction game in the lab1 FPGA designs. A single lit LED steps across `N` outputs at a programmable tick rate, in wrap or bounce mode. A player scores by raising exactly the switch under the lit LED. The block runs entirely on `clock`, using a clock-enable tick instead of a divided clock, and sits between the board switch/LED pins and an optional score display.

## Interface
Parameters:
- `N`, 4: LED/switch count; legal range N ≥ 2.
- `DIV`, 6250000: clock cycles per step tick; DIV ≥ 2.
- `HOLD_TICKS`, 4: ticks the all-on win pattern is held; ≥ 1.
- `SCORE_W`, 8: score counter width.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `switches`  in  N  raw board switches, asynchronous.
- `mode`  in  1  0 = wrap (N-1→0), 1 = bounce (ping-pong).
- `enable`  in  1  1 = run, 0 = pause stepping in RUN.
- `leds`  out  N  LED pattern.
- `win`  out  1  one-cycle pulse per hit.
- `miss`  out  1  one-cycle pulse per wrong press.
- `score`  out  SCORE_W  hit count, saturating.

## Operation
- **Input conditioning**
  - Two-flop synchroniser on `switches` produces `sw_s`.
  - A history register `sw_d` <= `sw_s` every clock.
  - `rise = sw_s & ~sw_d`.
- **Tick counter**
  - `cnt` runs 0..DIV-1 and wraps.
  - `tick` is high for one clock when `cnt == DIV-1`.
  - In RUN with `enable=0`, `cnt` freezes.
- **State RUN**
  - `leds` is one-hot at `pos` (width clog2(N)).
  - On `tick`, `pos` steps:
    - Wrap mode: +1, with N-1→0; `dir` is forced up.
    - Bounce mode: `pos` moves in `dir`. At N-1, `dir` flips to down and the step goes to N-2. At 0, `dir` flips to up and the step goes to 1.
- **Hit**
  - Condition: RUN and `rise == leds` exactly (only the lit bit rose).
  - Action: enter WIN, `score`+1 (holds at all-ones), `win` pulse, `cnt` cleared.
- **Miss**
  - Condition: RUN, `rise != 0`, and not a hit (wrong bit, or extra bits alongside the lit one).
  - Action: `pos` = 0, `dir` = up, `cnt` cleared, `miss` pulse, `score` unchanged.
- **Press while paused**: `rise` is evaluated while `enable=0`; hit and miss apply as in RUN.
- **State WIN**
  - `leds` = all ones.
  - `cnt` runs regardless of `enable`.
  - After HOLD_TICKS ticks, return to RUN with `pos=0`, `dir=up`, `cnt=0`.
  - `rise` is ignored in WIN; `sw_d` keeps tracking, so no stale edges appear on exit.
- **Mode change**
  - Takes effect at the next step.
  - Switching to bounce with `pos` at an end applies the end-turn rule above.
- **Priorities at one edge**: hit/miss > tick, so `pos` does not step on that edge.

## Timing
- **Reset values (asynchronous)**: `leds`=1 (pos 0), `score`=0, `win`=0, `miss`=0, state RUN, `dir` up, `cnt`=0, sync/history regs 0.
- **Switch latency**
  - A switch rising before edge k is in `sw_s` after edge k+1.
  - `rise` is high in the cycle after k+1 and is acted on at edge k+2.
  - `leds`, `score`, `win`/`miss` update after edge k+2.
- **Registered outputs**
  - `win`/`miss` are registered and high for exactly one clock.
  - `leds` is decoded only from registers; there is no combinational path from inputs.
- **Step period**: exactly DIV clocks in RUN with `enable=1`.
- **WIN duration**: HOLD_TICKS×DIV clocks.
- **Reset mid-WIN or mid-step**: immediate return to reset values, with no `win` pulse.

## Test plan
All scenarios use N=4, DIV=4, HOLD_TICKS=2, SCORE_W=3.
- **Reset and wrap stepping**: reset, mode=0, enable=1 → `leds` 0001,0010,0100,1000,0001 changing every 4 clocks; `win`=`miss`=0.
- **Bounce sequence**: mode=1 → `leds` 0001,0010,0100,1000,0100,0010,0001,0010.
- **Hit**: raise `switches[2]` while `leds`=0100 → 2 clocks later `leds`=1111 for 8 clocks, then 0001. `win` is high for 1 clock and `score`=1.
- **Miss and multi-press**:
  - Raise `switches[0]` while `leds`=0100 → `miss` pulse, `leds`=0001, `score` unchanged.
  - Raise `switches[2]` and `switches[3]` together at 0100 → miss.
- **Saturation, pause, WIN ignore**:
  - 8 hits → `score`=7.
  - enable=0 → `leds` frozen ≥20 clocks, and a hit is still accepted.
  - A press during WIN is ignored.
- **Tick collision and reset mid-WIN**:
  - Hit lands on the same edge as a tick → WIN is entered and `pos` does not step.
  - Asserting reset during WIN → `leds`=0001, `score`=0 immediately.
